// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-client cache-line read arbiter (mem_read_arb).
package mem_arb_pkg;

  localparam logic CLIENT_IC = 1'b0;
  localparam logic CLIENT_DC = 1'b1;

  localparam int unsigned CNT_W       = 3;
  localparam int unsigned REQ_ADDR_W  = 50;
  localparam int unsigned REQ_TRANS_W = 7;

  // Client request layout at the default NPHYS=56 / 64-byte line geometry.
  typedef struct packed {
    logic [REQ_ADDR_W-1:0]  addr;
    logic [REQ_TRANS_W-1:0] trans;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_req_buf.sv
// One-entry client request buffer with outstanding-read counter and accept generation.
module mem_arb_req_buf
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW     = 50,
  parameter int unsigned TW     = 7,
  parameter int unsigned MAXOUT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] raddr,
  input  logic [TW-1:0] raddr_trans,
  input  logic          raddr_req,
  output logic          raddr_ack,
  input  logic          grant,
  input  logic          ret,
  output logic          buf_valid,
  output logic [AW-1:0] buf_addr,
  output logic [TW-1:0] buf_trans
);

  logic [CNT_W-1:0] cnt;
  logic             take;
  logic             drop;

  always_comb begin
    raddr_ack = !buf_valid && (cnt < CNT_W'(MAXOUT));
    take      = raddr_req && raddr_ack;
    // A return with nothing counted (stale after reset) leaves cnt alone.
    drop      = ret && (cnt != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_trans <= '0;
      cnt       <= '0;
    end else begin
      if (take) begin
        buf_valid <= 1'b1;
        buf_addr  <= raddr;
        buf_trans <= raddr_trans;
      end else if (grant) begin
        buf_valid <= 1'b0;
      end
      if (take && !drop) begin
        cnt <= cnt + 1'b1;
      end else if (drop && !take) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_read_arb.sv
// Two-client (icache/dcache) line-fill read arbiter with tag-steered return path.
// Define MEM_ARB_FIXED_PRI_EN for fixed ic-over-dc priority instead of round-robin.
module mem_read_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned NPHYS            = 56,
  parameter int unsigned CACHE_LINE_SIZE  = 512,
  parameter int unsigned ACACHE_LINE_SIZE = $clog2(CACHE_LINE_SIZE/8),
  parameter int unsigned RTSIZE           = 8,
  parameter int unsigned MAXOUT           = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NPHYS-ACACHE_LINE_SIZE-1:0] ic_raddr,
  input  logic [RTSIZE-2:0]                 ic_raddr_trans,
  input  logic                              ic_raddr_req,
  output logic                              ic_raddr_ack,
  input  logic [NPHYS-ACACHE_LINE_SIZE-1:0] dc_raddr,
  input  logic [RTSIZE-2:0]                 dc_raddr_trans,
  input  logic                              dc_raddr_req,
  output logic                              dc_raddr_ack,
  output logic                              ic_rdata_req,
  input  logic                              ic_rdata_ack,
  output logic                              dc_rdata_req,
  input  logic                              dc_rdata_ack,
  output logic [CACHE_LINE_SIZE-1:0]        rdata,
  output logic [RTSIZE-2:0]                 rdata_trans,
  output logic [NPHYS-ACACHE_LINE_SIZE-1:0] mem_raddr,
  output logic [RTSIZE-1:0]                 mem_raddr_trans,
  output logic                              mem_raddr_req,
  input  logic                              mem_raddr_ack,
  input  logic [CACHE_LINE_SIZE-1:0]        mem_rdata,
  input  logic [RTSIZE-1:0]                 mem_rdata_trans,
  input  logic                              mem_rdata_req,
  output logic                              mem_rdata_ack
);

  localparam int unsigned AW = NPHYS - ACACHE_LINE_SIZE;
  localparam int unsigned TW = RTSIZE - 1;

  logic          ic_bv, dc_bv;
  logic [AW-1:0] ic_baddr, dc_baddr;
  logic [TW-1:0] ic_btrans, dc_btrans;
  logic          ic_grant, dc_grant;
  logic          ic_ret, dc_ret;
  logic          out_v;
  logic          load;
  logic          any_v;
  logic          win;
  logic          ret_tag;

  mem_arb_req_buf #(.AW(AW), .TW(TW), .MAXOUT(MAXOUT)) u_ic_buf (
    .clk         (clk),
    .reset       (reset),
    .raddr       (ic_raddr),
    .raddr_trans (ic_raddr_trans),
    .raddr_req   (ic_raddr_req),
    .raddr_ack   (ic_raddr_ack),
    .grant       (ic_grant),
    .ret         (ic_ret),
    .buf_valid   (ic_bv),
    .buf_addr    (ic_baddr),
    .buf_trans   (ic_btrans)
  );

  mem_arb_req_buf #(.AW(AW), .TW(TW), .MAXOUT(MAXOUT)) u_dc_buf (
    .clk         (clk),
    .reset       (reset),
    .raddr       (dc_raddr),
    .raddr_trans (dc_raddr_trans),
    .raddr_req   (dc_raddr_req),
    .raddr_ack   (dc_raddr_ack),
    .grant       (dc_grant),
    .ret         (dc_ret),
    .buf_valid   (dc_bv),
    .buf_addr    (dc_baddr),
    .buf_trans   (dc_btrans)
  );

  // The output register refills on the same edge its current entry is taken.
  always_comb begin
    load  = !out_v || mem_raddr_ack;
    any_v = ic_bv || dc_bv;
  end

`ifdef MEM_ARB_FIXED_PRI_EN
  always_comb begin
    win = ic_bv ? CLIENT_IC : CLIENT_DC;
  end
`else
  logic last;

  always_comb begin
    win = ic_bv ? CLIENT_IC : CLIENT_DC;
    if (ic_bv && dc_bv) begin
      win = ~last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= CLIENT_DC;
    end else if (load && any_v) begin
      last <= win;
    end
  end
`endif

  always_comb begin
    ic_grant = load && ic_bv && (win == CLIENT_IC);
    dc_grant = load && dc_bv && (win == CLIENT_DC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v           <= 1'b0;
      mem_raddr       <= '0;
      mem_raddr_trans <= '0;
    end else if (load) begin
      out_v <= any_v;
      if (any_v) begin
        mem_raddr       <= (win == CLIENT_IC) ? ic_baddr : dc_baddr;
        mem_raddr_trans <= {win, (win == CLIENT_IC) ? ic_btrans : dc_btrans};
      end
    end
  end

  // Return path is pure steering on the tag bit; no storage.
  always_comb begin
    mem_raddr_req = out_v;
    ret_tag       = mem_rdata_trans[RTSIZE-1];
    ic_rdata_req  = mem_rdata_req && (ret_tag == CLIENT_IC);
    dc_rdata_req  = mem_rdata_req && (ret_tag == CLIENT_DC);
    rdata         = mem_rdata;
    rdata_trans   = mem_rdata_trans[RTSIZE-2:0];
    mem_rdata_ack = (ret_tag == CLIENT_DC) ? dc_rdata_ack : ic_rdata_ack;
    ic_ret        = ic_rdata_req && mem_rdata_ack;
    dc_ret        = dc_rdata_req && mem_rdata_ack;
  end

endmodule

// File: tb/tb_mem_read_arb.sv
// Scoreboard bench for mem_read_arb: random client/memory traffic against a queue-based model.
module tb_mem_read_arb;
  import mem_arb_pkg::*;

  localparam int unsigned NPHYS  = 56;
  localparam int unsigned LINE   = 512;
  localparam int unsigned RTSIZE = 8;
  localparam int unsigned MAXOUT = 4;
  localparam int unsigned AW     = REQ_ADDR_W;
  localparam int unsigned TW     = REQ_TRANS_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [AW-1:0]     ic_raddr = '0, dc_raddr = '0;
  logic [TW-1:0]     ic_raddr_trans = '0, dc_raddr_trans = '0;
  logic              ic_raddr_req = 1'b0, dc_raddr_req = 1'b0;
  logic              ic_raddr_ack, dc_raddr_ack;
  logic              ic_rdata_req, dc_rdata_req;
  logic              ic_rdata_ack = 1'b0, dc_rdata_ack = 1'b0;
  logic [LINE-1:0]   rdata;
  logic [TW-1:0]     rdata_trans;
  logic [AW-1:0]     mem_raddr;
  logic [RTSIZE-1:0] mem_raddr_trans;
  logic              mem_raddr_req;
  logic              mem_raddr_ack = 1'b0;
  logic [LINE-1:0]   mem_rdata = '0;
  logic [RTSIZE-1:0] mem_rdata_trans = '0;
  logic              mem_rdata_req = 1'b0;
  logic              mem_rdata_ack;

  mem_read_arb #(
    .NPHYS           (NPHYS),
    .CACHE_LINE_SIZE (LINE),
    .RTSIZE          (RTSIZE),
    .MAXOUT          (MAXOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ic_raddr        (ic_raddr),
    .ic_raddr_trans  (ic_raddr_trans),
    .ic_raddr_req    (ic_raddr_req),
    .ic_raddr_ack    (ic_raddr_ack),
    .dc_raddr        (dc_raddr),
    .dc_raddr_trans  (dc_raddr_trans),
    .dc_raddr_req    (dc_raddr_req),
    .dc_raddr_ack    (dc_raddr_ack),
    .ic_rdata_req    (ic_rdata_req),
    .ic_rdata_ack    (ic_rdata_ack),
    .dc_rdata_req    (dc_rdata_req),
    .dc_rdata_ack    (dc_rdata_ack),
    .rdata           (rdata),
    .rdata_trans     (rdata_trans),
    .mem_raddr       (mem_raddr),
    .mem_raddr_trans (mem_raddr_trans),
    .mem_raddr_req   (mem_raddr_req),
    .mem_raddr_ack   (mem_raddr_ack),
    .mem_rdata       (mem_rdata),
    .mem_rdata_trans (mem_rdata_trans),
    .mem_rdata_req   (mem_rdata_req),
    .mem_rdata_ack   (mem_rdata_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RTSIZE-1:0] trans;
    logic [AW-1:0]     addr;
  } dn_t;

  typedef struct packed {
    logic            tag;
    logic [TW-1:0]   trans;
    logic [LINE-1:0] data;
  } ret_t;

  int errors = 0;
  int checks = 0;

  // Reference model: per-client queue of accepted-but-not-yet-issued requests,
  // per-client list of issued IDs awaiting return, and outstanding counts.
  mem_req_t      mq[2][$];
  logic [TW-1:0] infl[2][$];
  int            cnt[2] = '{0, 0};
  bit            outv = 1'b0;
  int unsigned   outc = 0;
  int unsigned   last = 1;

  dn_t  exp_q[$];
  ret_t ret_q[$];
  bit   exp_ack[2] = '{1'b1, 1'b1};
  bit   exp_mreq = 1'b0;
  bit   exp_cack[2] = '{1'b0, 1'b0};
  bit   mon_en = 1'b0;

  // Stimulus state
  bit            hold[2] = '{1'b0, 1'b0};
  mem_req_t      rq[2];
  int unsigned   p_req[2] = '{0, 0};
  int unsigned   p_mack = 0, p_ret = 0, p_cack = 0;
  bit            ret_act = 1'b0;
  logic          ret_tag = 1'b0;
  bit            dir_go = 1'b0;
  logic          dir_tag = 1'b0;
  logic [TW-1:0] dir_tr = '0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_ret(input logic tag, input logic [TW-1:0] tr);
    ret_t r;
    r.tag   = tag;
    r.trans = tr;
    for (int i = 0; i < int'(LINE / 32); i++) r.data[i*32 +: 32] = $urandom();
    ret_q.push_back(r);
    ret_act         = 1'b1;
    ret_tag         = tag;
    mem_rdata       = r.data;
    mem_rdata_trans = {tag, tr};
  endtask

  task automatic pick_ret();
    int unsigned c = $urandom_range(1);
    int unsigned k;
    if (infl[c].size() == 0) c = 1 - c;
    if (infl[c].size() != 0) begin
      k = $urandom_range(infl[c].size() - 1);
      start_ret(c[0], infl[c][k]);
      infl[c].delete(k);
    end
  endtask

  task automatic model_step();
    int          buffered[2];
    bit          acc[2];
    bit          dtx, load, any, retx, dec;
    int unsigned win;
    for (int c = 0; c < 2; c++) begin
      buffered[c] = mq[c].size() - ((outv && outc == c) ? 1 : 0);
      exp_ack[c]  = (buffered[c] == 0) && (cnt[c] < MAXOUT);
      acc[c]      = hold[c] && exp_ack[c];
    end
    exp_mreq    = outv;
    exp_cack[0] = ic_rdata_ack;
    exp_cack[1] = dc_rdata_ack;
    retx = ret_act && exp_cack[ret_tag];
    dtx  = outv && mem_raddr_ack;
    load = !outv || dtx;
    if (dtx) begin
      infl[outc].push_back(mq[outc][0].trans);
      void'(mq[outc].pop_front());
    end
    if (load) begin
      any = (buffered[0] > 0) || (buffered[1] > 0);
`ifdef MEM_ARB_FIXED_PRI_EN
      win = (buffered[0] > 0) ? 0 : 1;
`else
      if (buffered[0] > 0 && buffered[1] > 0) win = 1 - last;
      else win = (buffered[0] > 0) ? 0 : 1;
      if (any) last = win;
`endif
      outv = any;
      if (any) begin
        outc = win;
        exp_q.push_back('{trans: {win[0], mq[win][0].trans}, addr: mq[win][0].addr});
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (acc[c]) begin
        mq[c].push_back(rq[c]);
        hold[c] = 1'b0;
      end
      dec    = retx && (ret_tag == c[0]) && (cnt[c] > 0);
      cnt[c] = cnt[c] + (acc[c] ? 1 : 0) - (dec ? 1 : 0);
    end
    if (retx) ret_act = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      if (!hold[c] && $urandom_range(99) < p_req[c]) begin
        hold[c]     = 1'b1;
        rq[c].addr  = AW'({$urandom(), $urandom()});
        rq[c].trans = TW'($urandom());
      end
    end
    ic_raddr_req   = hold[0];
    ic_raddr       = rq[0].addr;
    ic_raddr_trans = rq[0].trans;
    dc_raddr_req   = hold[1];
    dc_raddr       = rq[1].addr;
    dc_raddr_trans = rq[1].trans;
    mem_raddr_ack  = ($urandom_range(99) < p_mack);
    if (dir_go && !ret_act) begin
      start_ret(dir_tag, dir_tr);
      dir_go = 1'b0;
    end else if (!ret_act && $urandom_range(99) < p_ret) begin
      pick_ret();
    end
    mem_rdata_req = ret_act;
    ic_rdata_ack  = ($urandom_range(99) < p_cack);
    dc_rdata_ack  = ($urandom_range(99) < p_cack);
    #1;
    model_step();
  endtask

  task automatic knobs(input int unsigned ri, input int unsigned rd, input int unsigned ma,
                       input int unsigned pr, input int unsigned ca);
    p_req[0] = ri;
    p_req[1] = rd;
    p_mack   = ma;
    p_ret    = pr;
    p_cack   = ca;
  endtask

  // Monitor: compares every DUT output presentation against model expectations.
  initial begin
    dn_t  e;
    ret_t r;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk1("ic_raddr_ack", ic_raddr_ack, exp_ack[0]);
        chk1("dc_raddr_ack", dc_raddr_ack, exp_ack[1]);
        chk1("mem_raddr_req", mem_raddr_req, exp_mreq);
        if (mem_raddr_req && exp_q.size() != 0 && !mem_raddr_ack)
          chkw("mem_raddr_hold", LINE'(mem_raddr), LINE'(exp_q[0].addr));
        if (mem_raddr_req && mem_raddr_ack) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL mem_raddr_unexpected: got trans %0h expected no request", mem_raddr_trans);
          end else begin
            e = exp_q.pop_front();
            chkw("mem_raddr", LINE'(mem_raddr), LINE'(e.addr));
            chkw("mem_raddr_trans", LINE'(mem_raddr_trans), LINE'(e.trans));
          end
        end
        if (mem_rdata_req) begin
          if (ret_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL ret_unexpected: got return with no expected entry");
          end else begin
            r = ret_q[0];
            chk1("ic_rdata_req", ic_rdata_req, !r.tag);
            chk1("dc_rdata_req", dc_rdata_req, r.tag);
            chkw("rdata", rdata, r.data);
            chkw("rdata_trans", LINE'(rdata_trans), LINE'(r.trans));
            chk1("mem_rdata_ack", mem_rdata_ack, exp_cack[r.tag]);
            if (mem_rdata_ack) void'(ret_q.pop_front());
          end
        end else begin
          chk1("ic_rdata_req_idle", ic_rdata_req, 1'b0);
          chk1("dc_rdata_req_idle", dc_rdata_req, 1'b0);
        end
      end
    end
  end

  initial begin
    logic          stale_tag;
    logic [TW-1:0] stale_tr;

    repeat (2) @(negedge clk);
    #1;
    chk1("rst_ic_ack", ic_raddr_ack, 1'b1);
    chk1("rst_dc_ack", dc_raddr_ack, 1'b1);
    chk1("rst_mem_req", mem_raddr_req, 1'b0);
    chkw("rst_mem_raddr", LINE'(mem_raddr), '0);
    chkw("rst_mem_trans", LINE'(mem_raddr_trans), '0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single ic request, then its return
    knobs(0, 0, 100, 0, 100);
    hold[0] = 1'b1;
    rq[0]   = '{addr: AW'(50'h1234), trans: TW'(7'h05)};
    repeat (4) step();
    dir_tag = 1'b0;
    dir_tr  = 7'h05;
    if (infl[0].size() != 0) void'(infl[0].pop_front());
    dir_go = 1'b1;
    repeat (3) step();

    // Both clients requesting continuously
    knobs(100, 100, 100, 100, 100);
    repeat (30) step();

    // Downstream stall then release
    knobs(100, 100, 0, 0, 100);
    repeat (12) step();
    knobs(100, 100, 100, 100, 100);
    repeat (10) step();
    knobs(0, 0, 100, 100, 100);
    repeat (25) step();

    // dc fills its outstanding limit, then a back-pressured return frees a slot
    knobs(0, 100, 100, 0, 100);
    repeat (10) step();
    knobs(0, 0, 100, 0, 0);
    repeat (2) step();
    if (infl[1].size() != 0) begin
      dir_tag = 1'b1;
      dir_tr  = infl[1][0];
      void'(infl[1].pop_front());
      dir_go  = 1'b1;
    end
    repeat (3) step();
    knobs(0, 100, 100, 0, 100);
    repeat (4) step();

    // Random traffic
    for (int ph = 0; ph < 6; ph++) begin
      knobs($urandom_range(100), $urandom_range(100), $urandom_range(20, 100),
            $urandom_range(20, 100), $urandom_range(30, 100));
      repeat (25) step();
    end

    // Build up in-flight requests, then reset asynchronously between edges
    knobs(60, 60, 100, 0, 100);
    repeat (10) step();
    stale_tag = 1'b1;
    stale_tr  = 7'h2a;
    if (infl[1].size() != 0) stale_tr = infl[1][0];
    else if (infl[0].size() != 0) begin
      stale_tag = 1'b0;
      stale_tr  = infl[0][0];
    end
    #2;
    reset         = 1'b1;
    mon_en        = 1'b0;
    hold          = '{1'b0, 1'b0};
    ic_raddr_req  = 1'b0;
    dc_raddr_req  = 1'b0;
    mem_rdata_req = 1'b0;
    ret_act       = 1'b0;
    dir_go        = 1'b0;
    #1;
    chk1("async_rst_ic_ack", ic_raddr_ack, 1'b1);
    chk1("async_rst_dc_ack", dc_raddr_ack, 1'b1);
    chk1("async_rst_mem_req", mem_raddr_req, 1'b0);
    chkw("async_rst_mem_raddr", LINE'(mem_raddr), '0);
    for (int c = 0; c < 2; c++) begin
      mq[c].delete();
      infl[c].delete();
      cnt[c] = 0;
    end
    outv = 1'b0;
    last = 1;
    exp_q.delete();
    ret_q.delete();
    exp_ack  = '{1'b1, 1'b1};
    exp_mreq = 1'b0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Late return from before the reset: forwarded, counter unaffected
    knobs(0, 0, 100, 0, 100);
    dir_tag = stale_tag;
    dir_tr  = stale_tr;
    dir_go  = 1'b1;
    repeat (3) step();
    knobs(100, 100, 100, 0, 100);
    repeat (10) step();
    knobs(0, 0, 100, 100, 100);
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_read_arb.md
# mem_read_arb

Two-client cache-line read arbiter sitting directly upstream of the memory interface's read address/read data channels. It accepts line-fill requests from the instruction cache and data cache, arbitrates them round-robin onto the single `mem_raddr` channel, and tags each downstream transaction with the client index. It then steers each returning `mem_rdata` line back to the owning cache by that tag. Per-client outstanding-request limits prevent one cache from monopolising the memory's transaction slots.

## Interface
- `NPHYS`, 56, physical address width
- `CACHE_LINE_SIZE`, 512, line width in bits
- `ACACHE_LINE_SIZE`, $clog2(CACHE_LINE_SIZE/8), line offset bits
- `RTSIZE`, 8, downstream read transaction ID width; bit RTSIZE-1 is the client tag
- `MAXOUT`, 4, maximum outstanding reads per client (1..7)
- `clk`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high reset
- `ic_raddr` / `dc_raddr`  in  NPHYS-ACACHE_LINE_SIZE  client line address
- `ic_raddr_trans` / `dc_raddr_trans`  in  RTSIZE-1  client transaction ID
- `ic_raddr_req` / `dc_raddr_req`  in  1  client request valid
- `ic_raddr_ack` / `dc_raddr_ack`  out  1  client request accepted
- `ic_rdata_req` / `dc_rdata_req`  out  1  returned line valid for this client
- `ic_rdata_ack` / `dc_rdata_ack`  in  1  client consumes returned line
- `rdata`  out  CACHE_LINE_SIZE  returned line (shared by both clients)
- `rdata_trans`  out  RTSIZE-1  returned client transaction ID (shared)
- `mem_raddr`  out  NPHYS-ACACHE_LINE_SIZE  downstream address
- `mem_raddr_trans`  out  RTSIZE  {client tag, client ID}; tag 0=ic, 1=dc
- `mem_raddr_req`  out  1  downstream request valid
- `mem_raddr_ack`  in  1  downstream accepts
- `mem_rdata`, `mem_rdata_trans`, `mem_rdata_req`  in  —  downstream return
- `mem_rdata_ack`  out  1  return consumed

## Operation
- Handshake rule (all channels): transfer occurs on a rising edge where req && ack are both high; req, address, and ID are held stable until the transfer.
- Per client: a one-entry request buffer plus an outstanding counter `cnt` (3 bits).
  - `x_raddr_ack` = !buf_valid && cnt < MAXOUT.
  - A client transfer loads the buffer and increments `cnt`.
- Output register (`mem_raddr*`): loads when empty or when it transfers this cycle, from the arbitration winner among valid buffers. The winner's buffer clears in the same edge.
- Round-robin: pointer `last` names the last-granted client. When both buffers are valid, the client other than `last` wins; a sole valid buffer always wins. `last` updates on each grant.
- Return path is combinational:
  - `ic_rdata_req` = mem_rdata_req && !mem_rdata_trans[RTSIZE-1]; `dc_rdata_req` is the tag-1 counterpart.
  - `rdata` = mem_rdata; `rdata_trans` = mem_rdata_trans[RTSIZE-2:0].
  - `mem_rdata_ack` = the tag-selected client's ack.
- A return transfer decrements the owning client's `cnt`. An increment and a decrement on the same edge leave `cnt` unchanged. A decrement at `cnt`==0 saturates at 0, and the line is still forwarded.

## Timing
- Reset values: all `*_raddr_ack` = 1, `mem_raddr_req` = 0, buffers empty, `cnt` = 0, `last` = dc (so ic wins the first tie), `mem_raddr`/`mem_raddr_trans` = 0.
- Request latency:
  - Client transfer at edge E: buffer valid after E, output loaded at E+1, `mem_raddr_req` high in the cycle after E+1.
  - If downstream acks continuously, sustained throughput is one request per cycle.
- A downstream stall (ack low) holds the output register. Buffers then fill and each client's ack drops.
- Return latency: zero cycles (pure steering). A client that holds its ack low backpressures the whole return channel.
- Asserting reset mid-operation clears all state immediately. Stale downstream returns are forwarded per their tag without affecting `cnt`.

## Configuration
- `MEM_ARB_FIXED_PRI_EN` defined: fixed priority, ic always beats dc; `last` is not implemented.
- Undefined: round-robin as described.

## Structure
- `mem_arb_pkg`: client tag localparams (CLIENT_IC=0, CLIENT_DC=1) and a request struct typedef {addr, trans}.
- Sub-module `mem_arb_req_buf`: one-entry buffer plus outstanding counter with ack generation, instantiated once per client. The top level holds arbitration, the output register, and return steering.

## Test plan
- Single ic request addr=0x1234, trans=0x05 with downstream ack=1 → `mem_raddr`=0x1234 and `mem_raddr_trans`=0x05 two cycles later; a return with trans 0x05 → `ic_rdata_req`=1, `dc_rdata_req`=0, `rdata_trans`=0x05.
- ic and dc request in the same cycle, repeatedly → downstream grants alternate ic, dc, ic, dc, with ic first after reset; with `MEM_ARB_FIXED_PRI_EN`, ic only until its `cnt` reaches 4.
- dc issues 4 requests with no returns → `dc_raddr_ack`=0 after the 4th; one return with tag 1 → ack=1 next cycle.
- Downstream ack held low for 10 cycles with both clients requesting → `mem_raddr` stable, both client acks 0; ack released → pending requests drain in round-robin order.
- Return with tag 1 while `dc_rdata_ack`=0 for 3 cycles → `mem_rdata_ack`=0 for 3 cycles; `dc cnt` decrements only on the ack cycle, and a simultaneous new dc request leaves `cnt` unchanged.
- Reset asserted asynchronously with 2 requests in flight → all acks 1 and `mem_raddr_req`=0 immediately; a late return is forwarded and `cnt` stays 0.
